// File: rtl/gfx_bus_master.sv
// rtl/gfx_bus_master.sv - shadow-register bus master: batched dirty-entry writes and single-register readback over a shared tristate bus
module gfx_bus_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        upd_valid,
    input  logic [3:0]  upd_addr,
    input  logic [15:0] upd_data,
    input  logic        flush,
    input  logic        rd_req,
    input  logic [3:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        flush_done,
    output logic        chipselect,
    output logic        read,
    output logic [3:0]  data_address,
    inout  wire  [15:0] databus
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ISSUE,
        RD_CAPTURE,
        TURN
    } state_t;

    localparam int NREG = 10;
    localparam logic [15:0] SHADOW_RST [NREG] = '{
        16'd320, 16'd240, 16'd320, 16'd240, 16'd320,
        16'd240, 16'd0,   16'd0,   16'd0,   16'd0
    };

    state_t            state, state_nxt;
    logic [15:0]       shadow [NREG];
    logic [NREG-1:0]   dirty, dirty_nxt, set_mask, clr_mask;
    logic              flush_pending, flush_req;
    logic              pending_clr, done_set;
    logic [3:0]        rd_addr_q;
    logic [3:0]        wr_idx;
    logic              upd_hit;
    logic              bus_drive;

    assign upd_hit   = upd_valid && (upd_addr <= 4'd9);
    assign flush_req = flush || flush_pending;
    assign busy      = (state != IDLE);

    // Lowest-index dirty entry goes out first.
    always_comb begin
        wr_idx = 4'd0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (dirty[i]) begin
                wr_idx = 4'(i);
            end
        end
    end

    // A same-cycle update re-sets the bit the write would clear, so the new value is sent later.
    always_comb begin
        set_mask  = upd_hit ? (NREG'(1) << upd_addr) : '0;
        clr_mask  = (state == WRITE) ? (NREG'(1) << wr_idx) : '0;
        dirty_nxt = (dirty & ~clr_mask) | set_mask;
    end

    always_comb begin
        state_nxt    = state;
        pending_clr  = 1'b0;
        done_set     = 1'b0;
        chipselect   = 1'b0;
        read         = 1'b0;
        data_address = 4'd0;
        bus_drive    = 1'b0;
        case (state)
            IDLE: begin
                if (rd_req) begin
                    state_nxt = RD_ISSUE;
                end else if (flush_req) begin
                    if (|dirty) begin
                        state_nxt = WRITE;
                    end else begin
                        pending_clr = 1'b1;
                        done_set    = 1'b1;
                    end
                end
            end
            WRITE: begin
                chipselect   = 1'b1;
                data_address = wr_idx;
                bus_drive    = 1'b1;
                if (dirty_nxt == '0) begin
                    state_nxt   = IDLE;
                    pending_clr = 1'b1;
                    done_set    = 1'b1;
                end
            end
            RD_ISSUE: begin
                chipselect   = 1'b1;
                read         = 1'b1;
                data_address = rd_addr_q;
                state_nxt    = RD_CAPTURE;
            end
            RD_CAPTURE: state_nxt = TURN;
            TURN:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    assign databus = bus_drive ? shadow[wr_idx] : 16'hzzzz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            dirty         <= '0;
            flush_pending <= 1'b0;
            rd_addr_q     <= 4'd0;
            rd_data       <= 16'd0;
            rd_valid      <= 1'b0;
            flush_done    <= 1'b0;
        end else begin
            state         <= state_nxt;
            dirty         <= dirty_nxt;
            flush_pending <= pending_clr ? 1'b0 : flush_req;
            flush_done    <= done_set;
            rd_valid      <= (state == RD_CAPTURE);
            if (state == IDLE && rd_req) begin
                rd_addr_q <= rd_addr;
            end
            if (state == RD_CAPTURE) begin
                rd_data <= databus;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                shadow[i] <= SHADOW_RST[i];
            end
        end else if (upd_hit) begin
            shadow[upd_addr] <= upd_data;
        end
    end

endmodule

// File: tb/tb_gfx_bus_master.sv
// tb/tb_gfx_bus_master.sv - scoreboard bench for gfx_bus_master with a registered bus responder
module tb_gfx_bus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        upd_valid = 1'b0;
    logic [3:0]  upd_addr = 4'd0;
    logic [15:0] upd_data = 16'd0;
    logic        flush = 1'b0;
    logic        rd_req = 1'b0;
    logic [3:0]  rd_addr = 4'd0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        flush_done;
    logic        chipselect;
    logic        read;
    logic [3:0]  data_address;
    wire  [15:0] databus;

    gfx_bus_master dut (
        .clk(clk), .rst(rst),
        .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_data(upd_data),
        .flush(flush), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .flush_done(flush_done),
        .chipselect(chipselect), .read(read), .data_address(data_address),
        .databus(databus)
    );

    always #5 clk = ~clk;

    // Responder: drives read data for exactly the cycle after it sees cs&read.
    logic [15:0] mem [10];
    logic        resp_drive = 1'b0;
    logic [15:0] resp_data = 16'd0;
    assign databus = resp_drive ? resp_data : 16'hzzzz;

    always @(posedge clk) begin
        if (chipselect && read) begin
            resp_drive <= 1'b1;
            resp_data  <= mem[data_address];
        end else begin
            resp_drive <= 1'b0;
        end
        if (chipselect && !read) begin
            mem[data_address] <= databus;
        end
    end

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int rv_cnt = 0;
    int rd_cyc = 0;
    logic [19:0] wq [$];
    logic [3:0]  raq [$];
    logic [15:0] rdq [$];

    always @(negedge clk) begin
        if (rst) begin
            if (chipselect && !read) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write actual addr=%0d data=%0d required none", data_address, databus);
                end else begin
                    logic [19:0] e;
                    e = wq.pop_front();
                    if ({data_address, databus} !== e) begin
                        errors++;
                        $display("FAIL write actual addr=%0d data=%0d required addr=%0d data=%0d",
                                 data_address, databus, e[19:16], e[15:0]);
                    end
                end
            end
            if (chipselect && read) begin
                rd_cyc++;
                checks++;
                if (raq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read actual addr=%0d required none", data_address);
                end else begin
                    logic [3:0] ea;
                    ea = raq.pop_front();
                    if (data_address !== ea) begin
                        errors++;
                        $display("FAIL read_addr actual=%0d required=%0d", data_address, ea);
                    end
                end
            end
            if (!chipselect) begin
                checks++;
                if (read !== 1'b0 || data_address !== 4'd0) begin
                    errors++;
                    $display("FAIL idle_bus actual read=%0b addr=%0d required read=0 addr=0", read, data_address);
                end
            end
            if (rd_valid) begin
                rv_cnt++;
                checks++;
                if (rdq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rd_valid actual data=%0d required none", rd_data);
                end else begin
                    logic [15:0] ed;
                    ed = rdq.pop_front();
                    if (rd_data !== ed) begin
                        errors++;
                        $display("FAIL rd_data actual=%0d required=%0d", rd_data, ed);
                    end
                end
            end
            if (flush_done) done_cnt++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic upd(input logic [3:0] a, input logic [15:0] d);
        upd_valid = 1'b1;
        upd_addr  = a;
        upd_data  = d;
        step();
        upd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int base, input int n0, input int exp);
        int n = n0;
        while (done_cnt == base && n < 30) begin
            step();
            n++;
        end
        chk({name, "_done_latency"}, (done_cnt != base) ? n : -1, exp);
        chk({name, "_busy_at_done"}, int'(busy), 0);
    endtask

    task automatic flush_and_wait(input string name, input int exp);
        int base = done_cnt;
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_done(name, base, 1, exp);
    endtask

    task automatic do_read(input logic [3:0] a, input logic [15:0] d);
        int base = rv_cnt;
        int rc = rd_cyc;
        int n = 1;
        raq.push_back(a);
        rdq.push_back(d);
        rd_req  = 1'b1;
        rd_addr = a;
        step();
        rd_req = 1'b0;
        while (rv_cnt == base && n < 30) begin
            step();
            n++;
        end
        chk("read_latency", (rv_cnt != base) ? n : -1, 3);
        chk("read_busy_in_turn", int'(busy), 1);
        chk("read_cs_cycles", rd_cyc - rc, 1);
        step();
        chk("read_busy_after", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int base, base_rv, rc, rv_n, done_n;
        for (int i = 0; i < 10; i++) mem[i] = (i == 6) ? 16'd730 : ((i % 2 == 0) ? 16'd320 : 16'd240);
        mem[9] = 16'hBEEF;

        step();
        chk("rst_cs", int'(chipselect), 0);
        chk("rst_read", int'(read), 0);
        chk("rst_addr", int'(data_address), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_flush_done", int'(flush_done), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        step();
        rst = 1'b1;
        step();

        // Two dirty entries written back-to-back
        upd(4'd1, 16'd100);
        upd(4'd4, 16'd500);
        wq.push_back({4'd1, 16'd100});
        wq.push_back({4'd4, 16'd500});
        flush_and_wait("flush2", 3);

        // Nothing dirty: done without bus activity
        flush_and_wait("flush_empty", 1);

        // Out-of-range updates are dropped
        upd(4'd12, 16'd999);
        upd(4'd15, 16'd5);
        flush_and_wait("flush_oor", 1);

        // Readback
        do_read(4'd6, 16'd730);
        do_read(4'd9, 16'hBEEF);

        // Update collides with the entry being written
        upd(4'd2, 16'd55);
        upd(4'd3, 16'd66);
        wq.push_back({4'd2, 16'd55});
        wq.push_back({4'd2, 16'd77});
        wq.push_back({4'd3, 16'd66});
        base = done_cnt;
        flush = 1'b1;
        step();
        flush = 1'b0;
        upd(4'd2, 16'd77);
        wait_done("collide", base, 2, 4);

        // Read and flush together: read first, write after TURN, rd_req during WRITE ignored
        upd(4'd0, 16'd11);
        wq.push_back({4'd0, 16'd11});
        raq.push_back(4'd5);
        rdq.push_back(16'd240);
        base = done_cnt;
        base_rv = rv_cnt;
        rc = rd_cyc;
        rv_n = -1;
        done_n = -1;
        rd_req = 1'b1;
        rd_addr = 4'd5;
        flush = 1'b1;
        step();
        rd_req = 1'b0;
        flush = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            if (rv_n < 0 && rv_cnt != base_rv) rv_n = n;
            if (done_n < 0 && done_cnt != base) done_n = n;
            if (n == 5) begin
                rd_req = 1'b1;
                rd_addr = 4'd6;
            end
            if (n == 6) rd_req = 1'b0;
            step();
        end
        chk("mixed_rd_valid_cycle", rv_n, 3);
        chk("mixed_done_cycle", done_n, 6);
        chk("mixed_read_cycles", rd_cyc - rc, 1);

        // Reset in the middle of a three-entry flush
        upd(4'd7, 16'd1);
        upd(4'd8, 16'd2);
        upd(4'd9, 16'd3);
        wq.push_back({4'd7, 16'd1});
        base = done_cnt;
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_cs", int'(chipselect), 0);
        chk("midrst_read", int'(read), 0);
        chk("midrst_addr", int'(data_address), 0);
        chk("midrst_busy", int'(busy), 0);
        step();
        step();
        chk("midrst_flush_done", int'(flush_done), 0);
        chk("midrst_rd_valid", int'(rd_valid), 0);
        rst = 1'b1;
        step();
        step();
        chk("midrst_no_done_pulse", done_cnt - base, 0);
        flush_and_wait("post_rst_flush", 1);

        chk("write_queue_empty", wq.size(), 0);
        chk("read_addr_queue_empty", raq.size(), 0);
        chk("read_data_queue_empty", rdq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
